// File: rtl/crc8_frame_tx.sv
// crc8_frame_tx
// Transmit-side framer for the optical link. Bytes arrive on a valid/ready
// stream into a one-byte holding register. Each frame goes out on the line as
// SYNC_BYTE, then the payload, then a CRC-8/EBU trailer over the payload
// (poly 0x1D, init 0xFF, reflected in/out). Every byte is sent LSB-first, and
// the line advances one bit per bit_en strobe. At least GAP_BITS idle strobes
// follow every frame or abort.
//
// Optional feature: define CRC8_FRAME_ERR_INJECT_EN to add the err_inject
// input. When it is high on the cycle a trailer is loaded, bit 0 of the
// transmitted trailer is inverted. crc_last still reports the true CRC.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   s_tdata      payload byte
//   s_tvalid     byte valid
//   s_tlast      byte is the last of its frame
//   s_tready     holding register empty (transfer on s_tvalid & s_tready)
//   bit_en       bit-rate strobe; all line activity advances only on it
//   err_inject   (CRC8_FRAME_ERR_INJECT_EN only) corrupt the next trailer
//   tx_bit       serial line data, 0 when not active
//   tx_active    high while SYNC, DATA or CRC bits are on the line
//   frame_done   one-cycle pulse after the last trailer bit
//   underrun     one-cycle pulse when a frame is aborted for lack of data
//   crc_last     reflected CRC of the most recent completed frame
module crc8_frame_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hD5,
  parameter int         GAP_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  input  logic       bit_en,
`ifdef CRC8_FRAME_ERR_INJECT_EN
  input  logic       err_inject,
`endif
  output logic       tx_bit,
  output logic       tx_active,
  output logic       frame_done,
  output logic       underrun,
  output logic [7:0] crc_last
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, GAP} state_t;

  localparam int            GW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  state_t        state, state_next;
  logic [7:0]    hold_data;
  logic          hold_last, hold_full;
  logic [7:0]    shifter;
  logic [2:0]    bit_cnt;
  logic [7:0]    crc, crc_next;
  logic          cur_last;
  logic [GW-1:0] gap_cnt;
  logic          last_bit;
  logic          load_sync, load_hold, load_trailer, end_frame, end_underrun;
  logic [7:0]    trailer_flip;

`ifdef CRC8_FRAME_ERR_INJECT_EN
  assign trailer_flip = {7'b0, err_inject};
`else
  assign trailer_flip = 8'h00;
`endif

  assign last_bit = bit_en & (bit_cnt == 3'd7);

  // Serial CRC step for the bit currently on the line. The register is kept
  // non-reflected; feeding bits LSB-first makes it equivalent to the reflected
  // CRC, so bitrev of the register is the reported/transmitted value.
  always_comb begin
    crc_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ shifter[0]) ? 8'h1D : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // When the gap ends with a byte already waiting, the next SYNC is loaded
  // directly so the line sees exactly GAP_BITS idle strobes between frames
  // regardless of how bit_en is spaced.
  always_comb begin
    state_next   = state;
    load_sync    = 1'b0;
    load_hold    = 1'b0;
    load_trailer = 1'b0;
    end_frame    = 1'b0;
    end_underrun = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load_sync  = 1'b1;
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (last_bit) begin
          if (hold_full) begin
            load_hold  = 1'b1;
            state_next = DATA;
          end else begin
            end_underrun = 1'b1;
            state_next   = GAP;
          end
        end
      end
      DATA: begin
        if (last_bit) begin
          if (cur_last) begin
            load_trailer = 1'b1;
            state_next   = CRC;
          end else if (hold_full) begin
            load_hold = 1'b1;
          end else begin
            end_underrun = 1'b1;
            state_next   = GAP;
          end
        end
      end
      CRC: begin
        if (last_bit) begin
          end_frame  = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (bit_en && (gap_cnt == GAP_LAST)) begin
          if (hold_full) begin
            load_sync  = 1'b1;
            state_next = SYNC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_active = (state == SYNC) || (state == DATA) || (state == CRC);
    tx_bit    = tx_active & shifter[0];
    s_tready  = ~hold_full & ~rst;
  end

  // Holding register. A load needs hold_full and a transfer needs it clear,
  // so the two never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      hold_last <= 1'b0;
    end else if (load_hold) begin
      hold_full <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      hold_full <= 1'b1;
      hold_data <= s_tdata;
      hold_last <= s_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shifter    <= 8'h00;
      bit_cnt    <= 3'd0;
      crc        <= 8'hFF;
      cur_last   <= 1'b0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      crc_last   <= 8'h00;
    end else begin
      frame_done <= end_frame;
      underrun   <= end_underrun;
      if (load_sync) begin
        shifter <= SYNC_BYTE;
        crc     <= 8'hFF;
        bit_cnt <= 3'd0;
      end else if (bit_en && tx_active) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (state == DATA) crc <= crc_next;
        if (load_hold) begin
          shifter  <= hold_data;
          cur_last <= hold_last;
        end else if (load_trailer) begin
          shifter <= bitrev8(crc_next) ^ trailer_flip;
        end else begin
          shifter <= {1'b0, shifter[7:1]};
        end
      end
      if (end_frame) crc_last <= bitrev8(crc);
      if (end_frame || end_underrun)  gap_cnt <= '0;
      else if (state == GAP && bit_en) gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Self-checking bench for crc8_frame_tx. Expected line content, one entry per
// bit_en strobe ({tx_active, tx_bit}), is queued when a frame is scheduled and
// popped as the DUT emits it; expected crc_last values are queued alongside.
module tb_crc8_frame_tx;

  localparam int GAP_BITS = 8;

  typedef logic [7:0] byte_q_t[$];
  typedef bit         bit_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic       bit_en;
`ifdef CRC8_FRAME_ERR_INJECT_EN
  logic       err_inject;
`endif
  logic       tx_bit;
  logic       tx_active;
  logic       frame_done;
  logic       underrun;
  logic [7:0] crc_last;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];
  logic [7:0] crc_q[$];
  bit         stop_drv = 1'b0;
  logic [7:0] last_good_crc;

  always #5 clk = ~clk;

  crc8_frame_tx #(.SYNC_BYTE(8'hD5), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk),
    .rst(rst),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tready(s_tready),
    .bit_en(bit_en),
`ifdef CRC8_FRAME_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .tx_bit(tx_bit),
    .tx_active(tx_active),
    .frame_done(frame_done),
    .underrun(underrun),
    .crc_last(crc_last)
  );

  // Byte-wise reflected CRC-8/EBU reference (poly 0x1D reflected = 0xB8).
  function automatic logic [7:0] ref_crc(input byte_q_t p);
    logic [7:0] c;
    c = 8'hFF;
    foreach (p[i]) begin
      c = c ^ p[i];
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 8'hB8) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, b[i]});
  endtask

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(2'b00);
  endtask

  task automatic push_frame(input byte_q_t p, input logic inj);
    logic [7:0] c;
    c = ref_crc(p);
    push_byte(8'hD5);
    foreach (p[i]) push_byte(p[i]);
    push_byte(c ^ {7'b0, inj});
    crc_q.push_back(c);
    push_idle(GAP_BITS);
    last_good_crc = c;
  endtask

  // Streams bytes into the DUT; enters and leaves just after a rising edge.
  task automatic send_stream(input byte_q_t data, input bit_q_t last, input bit rnd);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < data.size() && guard < 5000) begin
      s_tdata  = data[i];
      s_tlast  = last[i];
      s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (s_tvalid && s_tready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drive_strobes(input int div);
    int k;
    k = 0;
    while (!stop_drv) begin
      bit_en = ((k % div) == 0);
      k++;
      @(posedge clk);
      #1;
    end
    bit_en = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    bit_en   = 1'b0;
`ifdef CRC8_FRAME_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_bit, tx_active, frame_done, underrun, crc_last} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected 000",
               {tx_bit, tx_active, frame_done, underrun, crc_last});
    end
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tready: got %b, expected 0", s_tready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_tready, tx_active} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL post_reset_ready_active: got %b, expected 10", {s_tready, tx_active});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_check_vector;
    byte_q_t    p;
    bit_q_t     l;
    int         budget, done_cnt, und_cnt, idx;
    bit         started;
    logic [1:0] e;
    logic [7:0] ec;
    for (int i = 0; i < 9; i++) begin
      p.push_back(8'h31 + 8'(i));
      l.push_back(i == 8);
    end
    push_frame(p, 1'b0);
    budget = 2000; done_cnt = 0; und_cnt = 0; idx = 0; started = 1'b0;
    stop_drv = 1'b0;
    fork
      send_stream(p, l, 1'b0);
      drive_strobes(1);
      begin
        while (exp_q.size() > 0 && budget > 0) begin
          @(negedge clk);
          budget--;
          if (underrun) und_cnt++;
          if (frame_done) begin
            done_cnt++;
            ec = (crc_q.size() > 0) ? crc_q[0] : 8'hxx;
            if (crc_q.size() > 0) void'(crc_q.pop_front());
            checks++;
            if (crc_last !== ec) begin
              errors++;
              $display("[TB] FAIL chk_crc_last: got %h, expected %h", crc_last, ec);
            end
          end
          if (bit_en && (tx_active || started)) begin
            started = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if ({tx_active, tx_bit} !== e) begin
              errors++;
              $display("[TB] FAIL chk_line[%0d]: got %b, expected %b", idx, {tx_active, tx_bit}, e);
            end
            idx++;
          end
        end
        stop_drv = 1'b1;
      end
    join
    checks++;
    if (budget == 0) begin
      errors++;
      $display("[TB] FAIL chk_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (done_cnt !== 1 || und_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL chk_pulses: got done=%0d und=%0d, expected done=1 und=0", done_cnt, und_cnt);
    end
    checks++;
    if (crc_last !== 8'h97) begin
      errors++;
      $display("[TB] FAIL chk_crc_0x97: got %h, expected 97", crc_last);
    end
  endtask

  task automatic test_single_byte;
    byte_q_t    p;
    bit_q_t     l;
    int         budget, done_cnt, act_cnt, idx;
    bit         started;
    logic [1:0] e;
    logic [7:0] ec, res;
    logic       fb;
    p.push_back(8'h00);
    l.push_back(1'b1);
    push_frame(p, 1'b0);
    budget = 2000; done_cnt = 0; act_cnt = 0; idx = 0; started = 1'b0; res = 8'hFF;
    stop_drv = 1'b0;
    fork
      send_stream(p, l, 1'b0);
      drive_strobes(1);
      begin
        while (exp_q.size() > 0 && budget > 0) begin
          @(negedge clk);
          budget--;
          if (frame_done) begin
            done_cnt++;
            ec = (crc_q.size() > 0) ? crc_q[0] : 8'hxx;
            if (crc_q.size() > 0) void'(crc_q.pop_front());
            checks++;
            if (crc_last !== ec) begin
              errors++;
              $display("[TB] FAIL one_crc_last: got %h, expected %h", crc_last, ec);
            end
          end
          if (bit_en && tx_active) begin
            act_cnt++;
            // Independent reflected serial checker over payload + trailer.
            if (act_cnt > 8) begin
              fb  = res[0] ^ tx_bit;
              res = (res >> 1) ^ (fb ? 8'hB8 : 8'h00);
            end
          end
          if (bit_en && (tx_active || started)) begin
            started = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if ({tx_active, tx_bit} !== e) begin
              errors++;
              $display("[TB] FAIL one_line[%0d]: got %b, expected %b", idx, {tx_active, tx_bit}, e);
            end
            idx++;
          end
        end
        stop_drv = 1'b1;
      end
    join
    checks++;
    if (budget == 0) begin
      errors++;
      $display("[TB] FAIL one_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (act_cnt !== 24) begin
      errors++;
      $display("[TB] FAIL one_active_strobes: got %0d, expected 24", act_cnt);
    end
    checks++;
    if (res !== 8'h00) begin
      errors++;
      $display("[TB] FAIL one_residue: got %h, expected 00", res);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL one_done_count: got %0d, expected 1", done_cnt);
    end
  endtask

  task automatic test_underrun;
    byte_q_t    p;
    bit_q_t     l;
    int         budget, done_cnt, und_cnt, act_cnt, idx;
    bit         started;
    logic [1:0] e;
    logic [7:0] prev;
    prev = last_good_crc;
    p.push_back(8'h11);
    l.push_back(1'b0);
    push_byte(8'hD5);
    push_byte(8'h11);
    push_idle(GAP_BITS);
    budget = 2000; done_cnt = 0; und_cnt = 0; act_cnt = 0; idx = 0; started = 1'b0;
    stop_drv = 1'b0;
    fork
      send_stream(p, l, 1'b0);
      drive_strobes(1);
      begin
        while (exp_q.size() > 0 && budget > 0) begin
          @(negedge clk);
          budget--;
          if (frame_done) done_cnt++;
          if (underrun) begin
            und_cnt++;
            checks++;
            if (act_cnt !== 16) begin
              errors++;
              $display("[TB] FAIL und_position: got %0d strobes, expected 16", act_cnt);
            end
          end
          if (bit_en && tx_active) act_cnt++;
          if (bit_en && (tx_active || started)) begin
            started = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if ({tx_active, tx_bit} !== e) begin
              errors++;
              $display("[TB] FAIL und_line[%0d]: got %b, expected %b", idx, {tx_active, tx_bit}, e);
            end
            idx++;
          end
        end
        stop_drv = 1'b1;
      end
    join
    checks++;
    if (budget == 0) begin
      errors++;
      $display("[TB] FAIL und_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (und_cnt !== 1 || done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL und_pulses: got und=%0d done=%0d, expected und=1 done=0", und_cnt, done_cnt);
    end
    checks++;
    if (crc_last !== prev) begin
      errors++;
      $display("[TB] FAIL und_crc_last: got %h, expected %h", crc_last, prev);
    end
  endtask

  // Two 2-byte frames streamed without pause; div sets the strobe spacing and
  // rnd randomises s_tvalid. The line must match strobe-for-strobe either way.
  task automatic test_back_to_back(input int div, input bit rnd);
    byte_q_t    p, p1, p2;
    bit_q_t     l;
    int         budget, done_cnt, idle_cnt, idx;
    bit         started;
    logic [1:0] e;
    logic [7:0] ec;
    p1.push_back(8'h5A); p1.push_back(8'hC3);
    p2.push_back(8'h0F); p2.push_back(8'hE7);
    p = {p1, p2};
    l.push_back(1'b0); l.push_back(1'b1); l.push_back(1'b0); l.push_back(1'b1);
    push_frame(p1, 1'b0);
    push_frame(p2, 1'b0);
    budget = 4000; done_cnt = 0; idle_cnt = 0; idx = 0; started = 1'b0;
    stop_drv = 1'b0;
    fork
      send_stream(p, l, rnd);
      drive_strobes(div);
      begin
        while (exp_q.size() > 0 && budget > 0) begin
          @(negedge clk);
          budget--;
          if (frame_done) begin
            done_cnt++;
            ec = (crc_q.size() > 0) ? crc_q[0] : 8'hxx;
            if (crc_q.size() > 0) void'(crc_q.pop_front());
            checks++;
            if (crc_last !== ec) begin
              errors++;
              $display("[TB] FAIL b2b_crc_last(div=%0d): got %h, expected %h", div, crc_last, ec);
            end
          end
          if (bit_en && (tx_active || started)) begin
            started = 1'b1;
            if (!tx_active) idle_cnt++;
            e = exp_q.pop_front();
            checks++;
            if ({tx_active, tx_bit} !== e) begin
              errors++;
              $display("[TB] FAIL b2b_line(div=%0d)[%0d]: got %b, expected %b",
                       div, idx, {tx_active, tx_bit}, e);
            end
            idx++;
          end
        end
        stop_drv = 1'b1;
      end
    join
    checks++;
    if (budget == 0) begin
      errors++;
      $display("[TB] FAIL b2b_timeout(div=%0d): got %0d pending, expected 0", div, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (done_cnt !== 2 || idle_cnt !== 2 * GAP_BITS) begin
      errors++;
      $display("[TB] FAIL b2b_counts(div=%0d): got done=%0d idle=%0d, expected done=2 idle=%0d",
               div, done_cnt, idle_cnt, 2 * GAP_BITS);
    end
  endtask

`ifdef CRC8_FRAME_ERR_INJECT_EN
  task automatic test_err_inject;
    byte_q_t    p;
    bit_q_t     l;
    int         budget, done_cnt, idx;
    bit         started;
    logic [1:0] e;
    logic [7:0] ec;
    for (int i = 0; i < 9; i++) begin
      p.push_back(8'h31 + 8'(i));
      l.push_back(i == 8);
    end
    push_frame(p, 1'b1);
    err_inject = 1'b1;
    budget = 2000; done_cnt = 0; idx = 0; started = 1'b0;
    stop_drv = 1'b0;
    fork
      send_stream(p, l, 1'b0);
      drive_strobes(1);
      begin
        while (exp_q.size() > 0 && budget > 0) begin
          @(negedge clk);
          budget--;
          if (frame_done) begin
            done_cnt++;
            ec = (crc_q.size() > 0) ? crc_q[0] : 8'hxx;
            if (crc_q.size() > 0) void'(crc_q.pop_front());
            checks++;
            if (crc_last !== ec) begin
              errors++;
              $display("[TB] FAIL inj_crc_last: got %h, expected %h", crc_last, ec);
            end
          end
          if (bit_en && (tx_active || started)) begin
            started = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if ({tx_active, tx_bit} !== e) begin
              errors++;
              $display("[TB] FAIL inj_line[%0d]: got %b, expected %b", idx, {tx_active, tx_bit}, e);
            end
            idx++;
          end
        end
        stop_drv = 1'b1;
      end
    join
    err_inject = 1'b0;
    checks++;
    if (budget == 0 || done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL inj_done: got done=%0d pending=%0d, expected done=1 pending=0",
               done_cnt, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (crc_last !== 8'h97) begin
      errors++;
      $display("[TB] FAIL inj_crc_0x97: got %h, expected 97", crc_last);
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    byte_q_t p;
    bit_q_t  l;
    int      budget, act_cnt, bad_cnt;
    logic [7:0] prev;
    prev = last_good_crc;
    p.push_back(8'h81); p.push_back(8'h42);
    l.push_back(1'b0);  l.push_back(1'b1);
    budget = 2000; act_cnt = 0; bad_cnt = 0;
    stop_drv = 1'b0;
    fork
      send_stream(p, l, 1'b0);
      drive_strobes(1);
      begin
        while (act_cnt < 12 && budget > 0) begin
          @(negedge clk);
          budget--;
          if (bit_en && tx_active) act_cnt++;
        end
        checks++;
        if (act_cnt !== 12) begin
          errors++;
          $display("[TB] FAIL rstmid_reach_data: got %0d strobes, expected 12", act_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_active, s_tready} !== 2'b01) begin
          errors++;
          $display("[TB] FAIL rstmid_after: got active,ready=%b, expected 01", {tx_active, s_tready});
        end
        repeat (40) begin
          @(negedge clk);
          if (tx_active || frame_done || underrun) bad_cnt++;
        end
        checks++;
        if (bad_cnt !== 0) begin
          errors++;
          $display("[TB] FAIL rstmid_quiet: got %0d busy cycles, expected 0", bad_cnt);
        end
        checks++;
        if (crc_last !== 8'h00) begin
          errors++;
          $display("[TB] FAIL rstmid_crc_last: got %h, expected 00 (was %h before reset)", crc_last, prev);
        end
        stop_drv = 1'b1;
      end
    join
  endtask

  initial begin
    last_good_crc = 8'h00;
    test_reset();
    test_check_vector();
    test_single_byte();
    test_underrun();
    test_back_to_back(1, 1'b0);
    test_back_to_back(3, 1'b1);
`ifdef CRC8_FRAME_ERR_INJECT_EN
    test_err_inject();
`endif
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 400000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
